// File: rtl/ir_mon_pkg.sv
// Shared types and helpers for the IR event monitor.
package ir_mon_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mon_state_t;

  localparam int SYNC_DEPTH  = 2;
  localparam int SLICE_BUS_W = 64;
  localparam int SLICE_W     = 16;

  // Extract field ch of width w from a packed per-channel bus (ch0 in LSBs).
  function automatic logic [SLICE_W-1:0] ch_slice(input logic [SLICE_BUS_W-1:0] bus,
                                                   input int ch, input int w);
    logic [SLICE_W-1:0] mask;
    mask = (SLICE_W'(1) << w) - SLICE_W'(1);
    return SLICE_W'(bus >> (ch * w)) & mask;
  endfunction

endpackage

// File: rtl/ir_pulse_qual.sv
// Per-channel input path: synchroniser, polarity normalisation and
// minimum-width filter producing one qualify strobe per active period.
module ir_pulse_qual
  import ir_mon_pkg::*;
#(
  parameter int MIN_W   = 4,
  parameter bit ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  input  logic i_clr,
  output logic o_qual
);

  localparam int   WW       = $clog2(MIN_W + 1);
  localparam logic INACTIVE = ACT_LOW;

  logic [SYNC_DEPTH-1:0] r_sync;
  logic [WW-1:0]         r_width;
  logic                  w_act;

  assign w_act  = r_sync[SYNC_DEPTH-1] ^ INACTIVE;
  assign o_qual = w_act && !i_clr && (r_width == WW'(MIN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {SYNC_DEPTH{INACTIVE}};
    else        r_sync <= {r_sync[SYNC_DEPTH-2:0], i_sig};
  end

  // Clearing parks the counter at MIN_W so a pulse already in progress is
  // ignored until the line has been seen inactive again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_width <= '0;
    else if (i_clr)                     r_width <= WW'(MIN_W);
    else if (!w_act)                    r_width <= '0;
    else if (r_width != WW'(MIN_W))     r_width <= r_width + 1'b1;
  end

endmodule

// File: rtl/ir_event_monitor.sv
// Multi-channel IR pulse monitor: counts qualified pulses per channel against
// latched expectations within a cycle budget; reports pass/timeout/over-count.
module ir_event_monitor
  import ir_mon_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 4,
  parameter int TMO_W   = 24,
  parameter int MIN_W   = 4,
  parameter bit ACT_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_arm,
  input  logic [TMO_W-1:0]        i_tmo_cycles,
  input  logic [NUM_CH*CNT_W-1:0] i_exp_cnt,
  input  logic [NUM_CH-1:0]       i_sig_in,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_err_tmo,
  output logic [NUM_CH-1:0]       o_err_over,
  output logic [NUM_CH*CNT_W-1:0] o_pulse_cnt
);

  mon_state_t              r_state, w_state_next;
  logic [NUM_CH*CNT_W-1:0] r_exp, r_cnt, w_cnt_next;
  logic [TMO_W-1:0]        r_tmo;
  logic                    r_tmo_en, r_pass, r_err_tmo;
  logic [NUM_CH-1:0]       r_err_over, w_qual, w_over, w_match;
  logic                    w_tmo_hit;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] w_cur, w_exp, w_inc;

      ir_pulse_qual #(.MIN_W(MIN_W), .ACT_LOW(ACT_LOW)) u_qual (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (i_sig_in[gi]),
        .i_clr  (i_arm),
        .o_qual (w_qual[gi])
      );

      assign w_cur = r_cnt[gi*CNT_W +: CNT_W];
      assign w_exp = CNT_W'(ch_slice(SLICE_BUS_W'(r_exp), gi, CNT_W));
      assign w_inc = (w_qual[gi] && (w_cur != '1)) ? w_cur + 1'b1 : w_cur;
      assign w_cnt_next[gi*CNT_W +: CNT_W] = w_inc;
      assign w_over[gi]  = (w_inc > w_exp);
      assign w_match[gi] = (w_inc == w_exp);
    end
  endgenerate

  // Budget of N expires on the Nth RUN cycle after entry.
  assign w_tmo_hit = r_tmo_en && (r_tmo == TMO_W'(1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_arm) w_state_next = RUN;
      RUN:     if (i_arm) w_state_next = RUN;
               else if ((|w_over) || (&w_match) || w_tmo_hit) w_state_next = DONE;
      DONE:    if (i_arm) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp      <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_tmo_en   <= 1'b0;
      r_pass     <= 1'b0;
      r_err_tmo  <= 1'b0;
      r_err_over <= '0;
    end else if (i_arm) begin
      r_exp      <= i_exp_cnt;
      r_cnt      <= '0;
      r_tmo      <= i_tmo_cycles;
      r_tmo_en   <= |i_tmo_cycles;
      r_pass     <= 1'b0;
      r_err_tmo  <= 1'b0;
      r_err_over <= '0;
    end else if (r_state == RUN) begin
      r_cnt <= w_cnt_next;
      if (r_tmo_en) r_tmo <= r_tmo - 1'b1;
      // Over-count outranks completion, which outranks timeout.
      if (|w_over)        r_err_over <= w_over;
      else if (&w_match)  r_pass     <= 1'b1;
      else if (w_tmo_hit) r_err_tmo  <= 1'b1;
    end
  end

  assign o_busy      = (r_state == RUN);
  assign o_done      = (r_state == DONE);
  assign o_pass      = r_pass;
  assign o_err_tmo   = r_err_tmo;
  assign o_err_over  = r_err_over;
  assign o_pulse_cnt = r_cnt;

endmodule
